// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg : shared state and unit encodings for the ALU op sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_mux.sv
// ---------------------------------------------------------------------------
// alu_result_mux : picks flag, zero-extended result and carry of one ALU unit
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_result_mux
  import alu_seq_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int RES_WIDTH = 32,
  parameter int CMP_WIDTH = 3
) (
  input  logic [1:0]           unit_sel,
  input  logic                 arith_flag,
  input  logic                 logic_flag,
  input  logic                 cmp_flag,
  input  logic                 shift_flag,
  input  logic [RES_WIDTH-1:0] arith_res,
  input  logic                 carry,
  input  logic [A_WIDTH-1:0]   logic_res,
  input  logic [CMP_WIDTH-1:0] cmp_res,
  input  logic [A_WIDTH-1:0]   shift_res,
  output logic                 sel_flag,
  output logic [RES_WIDTH-1:0] sel_data,
  output logic                 sel_carry
);

  always_comb begin
    sel_flag  = 1'b0;
    sel_data  = '0;
    sel_carry = 1'b0;
    case (unit_sel)
      UNIT_ARITH: begin
        sel_flag  = arith_flag;
        sel_data  = arith_res;
        sel_carry = carry;
      end
      UNIT_LOGIC: begin
        sel_flag = logic_flag;
        sel_data = RES_WIDTH'(logic_res);
      end
      UNIT_CMP: begin
        sel_flag = cmp_flag;
        sel_data = RES_WIDTH'(cmp_res);
      end
      default: begin
        sel_flag = shift_flag;
        sel_data = RES_WIDTH'(shift_res);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer : issues one op to the ALU, waits a fixed latency, returns
//                    the selected unit's result over a response handshake
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int RES_WIDTH = A_WIDTH + B_WIDTH,
  parameter int CMP_WIDTH = 3,
  parameter int ALU_LAT   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK_SEQ,
  input  logic                 RST_SEQ,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [A_WIDTH-1:0]   REQ_A,
  input  logic [B_WIDTH-1:0]   REQ_B,
  input  logic [3:0]           REQ_FUN,
  output logic [A_WIDTH-1:0]   A_OUT,
  output logic [B_WIDTH-1:0]   B_OUT,
  output logic [3:0]           FUN_OUT,
  input  logic                 ARITH_FLAG_IN,
  input  logic                 LOGIC_FLAG_IN,
  input  logic                 CMP_FLAG_IN,
  input  logic                 SHIFT_FLAG_IN,
  input  logic [RES_WIDTH-1:0] ARITH_IN,
  input  logic                 CARRY_IN,
  input  logic [A_WIDTH-1:0]   LOGIC_IN,
  input  logic [CMP_WIDTH-1:0] CMP_IN,
  input  logic [A_WIDTH-1:0]   SHIFT_IN,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [RES_WIDTH-1:0] RSP_DATA,
  output logic                 RSP_CARRY,
  output logic [1:0]           RSP_UNIT,
  output logic                 RSP_ERR,
  output logic [CNT_WIDTH-1:0] OP_CNT,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  localparam logic [3:0] LAT_VAL = 4'(ALU_LAT);

  seq_state_t           state;
  seq_state_t           next_state;
  logic [3:0]           lat_cnt;
  logic                 accept;
  logic                 sample;
  logic                 handshake;
  logic                 sel_flag;
  logic [RES_WIDTH-1:0] sel_data;
  logic                 sel_carry;

  alu_result_mux #(
    .A_WIDTH   (A_WIDTH),
    .RES_WIDTH (RES_WIDTH),
    .CMP_WIDTH (CMP_WIDTH)
  ) u_mux (
    .unit_sel   (FUN_OUT[3:2]),
    .arith_flag (ARITH_FLAG_IN),
    .logic_flag (LOGIC_FLAG_IN),
    .cmp_flag   (CMP_FLAG_IN),
    .shift_flag (SHIFT_FLAG_IN),
    .arith_res  (ARITH_IN),
    .carry      (CARRY_IN),
    .logic_res  (LOGIC_IN),
    .cmp_res    (CMP_IN),
    .shift_res  (SHIFT_IN),
    .sel_flag   (sel_flag),
    .sel_data   (sel_data),
    .sel_carry  (sel_carry)
  );

  always_ff @(posedge CLK_SEQ or posedge RST_SEQ) begin
    if (RST_SEQ) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          accept     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_VAL) begin
          sample     = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake flags depend on registered state only.
  assign REQ_READY = (state == IDLE);
  assign RSP_VALID = (state == RESP);
  assign handshake = RSP_VALID && RSP_READY;

  always_ff @(posedge CLK_SEQ or posedge RST_SEQ) begin
    if (RST_SEQ) begin
      A_OUT     <= '0;
      B_OUT     <= '0;
      FUN_OUT   <= '0;
      lat_cnt   <= '0;
      RSP_DATA  <= '0;
      RSP_CARRY <= 1'b0;
      RSP_UNIT  <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      if (accept) begin
        A_OUT   <= REQ_A;
        B_OUT   <= REQ_B;
        FUN_OUT <= REQ_FUN;
        lat_cnt <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (sample) begin
        RSP_DATA  <= sel_flag ? sel_data : '0;
        RSP_CARRY <= sel_flag & sel_carry;
        RSP_ERR   <= ~sel_flag;
        RSP_UNIT  <= FUN_OUT[3:2];
      end
    end
  end

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge CLK_SEQ or posedge RST_SEQ) begin
    if (RST_SEQ) begin
      OP_CNT  <= '0;
      ERR_CNT <= '0;
    end else if (handshake) begin
      if (OP_CNT != '1)             OP_CNT  <= OP_CNT + CNT_WIDTH'(1);
      if (RSP_ERR && ERR_CNT != '1) ERR_CNT <= ERR_CNT + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer : directed self-checking bench with a hand-driven ALU stub
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_fun;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [3:0]  fun_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [31:0] arith_in;
  logic        carry_in;
  logic [15:0] logic_in;
  logic [2:0]  cmp_in;
  logic [15:0] shift_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic [1:0]  rsp_unit;
  logic        rsp_err;
  logic [15:0] op_cnt;
  logic [15:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .CLK_SEQ       (clk),
    .RST_SEQ       (rst),
    .REQ_VALID     (req_valid),
    .REQ_READY     (req_ready),
    .REQ_A         (req_a),
    .REQ_B         (req_b),
    .REQ_FUN       (req_fun),
    .A_OUT         (a_out),
    .B_OUT         (b_out),
    .FUN_OUT       (fun_out),
    .ARITH_FLAG_IN (arith_flag),
    .LOGIC_FLAG_IN (logic_flag),
    .CMP_FLAG_IN   (cmp_flag),
    .SHIFT_FLAG_IN (shift_flag),
    .ARITH_IN      (arith_in),
    .CARRY_IN      (carry_in),
    .LOGIC_IN      (logic_in),
    .CMP_IN        (cmp_in),
    .SHIFT_IN      (shift_in),
    .RSP_VALID     (rsp_valid),
    .RSP_READY     (rsp_ready),
    .RSP_DATA      (rsp_data),
    .RSP_CARRY     (rsp_carry),
    .RSP_UNIT      (rsp_unit),
    .RSP_ERR       (rsp_err),
    .OP_CNT        (op_cnt),
    .ERR_CNT       (err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stub_clear();
    arith_flag = 1'b0; logic_flag = 1'b0; cmp_flag = 1'b0; shift_flag = 1'b0;
    arith_in = '0; carry_in = 1'b0; logic_in = '0; cmp_in = '0; shift_in = '0;
  endtask

  // Presents a request before edge T; returns inside cycle T+3 (sample cycle).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    req_valid = 1'b1; req_a = a; req_b = b; req_fun = fun;
    @(negedge clk);
    req_valid = 1'b0;
    chk("accept_ready_low", 64'(req_ready), 64'd0);
    chk("a_out_captured", 64'(a_out), 64'(a));
    chk("fun_out_captured", 64'(fun_out), 64'(fun));
    @(negedge clk);
    chk("no_early_valid_t2", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("no_early_valid_t3", 64'(rsp_valid), 64'd0);
  endtask

  task automatic complete(input logic [15:0] exp_ops, input logic [15:0] exp_errs);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_hs", 64'(req_ready), 64'd1);
    chk("valid_drop", 64'(rsp_valid), 64'd0);
    chk("op_cnt", 64'(op_cnt), 64'(exp_ops));
    chk("err_cnt", 64'(err_cnt), 64'(exp_errs));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_fun = '0; rsp_ready = 1'b0;
    stub_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_outputs", 64'({a_out, b_out, fun_out, rsp_unit, rsp_carry, rsp_err}), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_counters", 64'({op_cnt, err_cnt}), 64'd0);

    // Arith add: flag valid only in the sample cycle T+3.
    issue(16'h0003, 16'h0004, 4'b0000);
    chk("add_b_out", 64'(b_out), 64'h4);
    arith_flag = 1'b1; arith_in = 32'h7; carry_in = 1'b0;
    @(negedge clk);
    stub_clear();
    chk("add_valid_t4", 64'(rsp_valid), 64'd1);
    chk("add_data", 64'(rsp_data), 64'h7);
    chk("add_unit_err_carry", 64'({rsp_unit, rsp_err, rsp_carry}), 64'd0);
    complete(16'd1, 16'd0);

    // Compare, with the arith unit also flagging: arith must be ignored.
    issue(16'h0005, 16'h0006, 4'b1001);
    cmp_flag = 1'b1; cmp_in = 3'b010;
    arith_flag = 1'b1; arith_in = 32'hFFFF_FFFF; carry_in = 1'b1;
    @(negedge clk);
    stub_clear();
    chk("cmp_valid", 64'(rsp_valid), 64'd1);
    chk("cmp_data", 64'(rsp_data), 64'h2);
    chk("cmp_carry", 64'(rsp_carry), 64'd0);
    chk("cmp_unit", 64'(rsp_unit), 64'h2);
    chk("cmp_err", 64'(rsp_err), 64'd0);
    complete(16'd2, 16'd0);

    // Shift with its own flag low; all others high.
    issue(16'h00F0, 16'h0004, 4'b1100);
    shift_flag = 1'b0; shift_in = 16'hABCD;
    arith_flag = 1'b1; logic_flag = 1'b1; cmp_flag = 1'b1; carry_in = 1'b1;
    arith_in = 32'h1234_5678;
    @(negedge clk);
    stub_clear();
    chk("miss_err", 64'(rsp_err), 64'd1);
    chk("miss_data", 64'(rsp_data), 64'd0);
    chk("miss_carry", 64'(rsp_carry), 64'd0);
    chk("miss_unit", 64'(rsp_unit), 64'h3);

    // Backpressure with a pending request that must not be captured.
    req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h5678; req_fun = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp", 64'({rsp_data, rsp_unit, rsp_err, rsp_carry}), 64'({32'd0, 2'b11, 1'b1, 1'b0}));
      chk("bp_no_capture", 64'({a_out, b_out, fun_out}), 64'({16'h00F0, 16'h0004, 4'b1100}));
    end
    complete(16'd3, 16'd1);
    // Still valid: accepted at the edge closing this IDLE cycle.
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_a_out", 64'(a_out), 64'h1234);
    chk("b2b_b_out", 64'(b_out), 64'h5678);
    chk("b2b_fun_out", 64'(fun_out), 64'h6);
    chk("b2b_busy", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    logic_flag = 1'b1; logic_in = 16'hBEEF;
    @(negedge clk);
    stub_clear();
    chk("logic_valid", 64'(rsp_valid), 64'd1);
    chk("logic_data", 64'(rsp_data), 64'h0000_BEEF);
    chk("logic_unit", 64'(rsp_unit), 64'h1);
    chk("logic_err", 64'(rsp_err), 64'd0);
    complete(16'd4, 16'd1);

    // Reset in cycle T+2 drops the op entirely.
    req_valid = 1'b1; req_a = 16'h0001; req_b = 16'h0001; req_fun = 4'b0000;
    @(negedge clk);
    req_valid = 1'b0;
    arith_flag = 1'b1; logic_flag = 1'b1; cmp_flag = 1'b1; shift_flag = 1'b1;
    arith_in = 32'h2;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_idle", 64'(req_ready), 64'd1);
    chk("midrst_counters", 64'({op_cnt, err_cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd1);
    end
    chk("midrst_op_cnt", 64'(op_cnt), 64'd0);
    chk("midrst_a_out", 64'(a_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
